// File: rtl/noc_in_buffer_if.sv
// Link/route-compute handshake bundle for one router input port.
// master: upstream link plus route-compute stage; slave: the ingress buffer.
interface noc_in_buffer_if #(
   parameter int DATASIZE = 40
);
   logic [DATASIZE-1:0] link_data_in;
   logic                link_valid_in;
   logic                link_ready_out;
   logic                fifo_ready;
   logic [DATASIZE-1:0] data_out;
   logic                valid_out;

   modport master (
      output link_data_in, link_valid_in, fifo_ready,
      input  link_ready_out, data_out, valid_out
   );

   modport slave (
      input  link_data_in, link_valid_in, fifo_ready,
      output link_ready_out, data_out, valid_out
   );
endinterface

// File: rtl/noc_in_buffer.sv
// Per-input-port ingress FIFO of the router.
// Flits are stored opaquely. A pop presents the head flit one cycle later on
// data_out/valid_out. A flit offered while full is dropped and sets a sticky
// overflow flag.
module noc_in_buffer #(
   parameter int DATASIZE = 40,
   parameter int DEPTH    = 4,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic            rc_clk,
   input  logic            rst_n,
   noc_in_buffer_if.slave  bus,
   output logic            empty,
   output logic            full,
   output logic [AW:0]     count,
   output logic            overflow
);

   logic [DATASIZE-1:0] mem [DEPTH];
   logic [AW:0]         wr_ptr, rd_ptr;
   logic [AW-1:0]       wr_idx, rd_idx;
   logic                push, pop;

   // Status decode uses registers only, so link_ready_out has no path from inputs.
   always_comb begin
      wr_idx = wr_ptr[AW-1:0];
      rd_idx = rd_ptr[AW-1:0];
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_idx == rd_idx) && (wr_ptr[AW] != rd_ptr[AW]);
      count  = wr_ptr - rd_ptr;
      bus.link_ready_out = !full;
      // Push is gated on the registered full: a same-cycle pop never frees a slot.
      push   = bus.link_valid_in && !full;
      pop    = bus.fifo_ready && !empty;
   end

   // Storage array; contents are deliberately left unreset.
   always_ff @(posedge rc_clk) begin
      if (push) mem[wr_idx] <= bus.link_data_in;
   end

   // Pointers, registered output stage and sticky overflow.
   always_ff @(posedge rc_clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         bus.data_out  <= '0;
         bus.valid_out <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            bus.data_out  <= mem[rd_idx];
            rd_ptr        <= rd_ptr + 1'b1;
            bus.valid_out <= 1'b1;
         end else begin
            bus.valid_out <= 1'b0;
         end
         if (bus.link_valid_in && full) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_noc_in_buffer.sv
// Self-checking bench for noc_in_buffer: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_noc_in_buffer;
   localparam int DW = 40;
   localparam int DEPTH = 4;
   localparam int AW = 2;

   logic rc_clk = 1'b0;
   logic rst_n  = 1'b0;
   logic empty, full, overflow;
   logic [AW:0] count;

   noc_in_buffer_if #(.DATASIZE(DW)) bus ();

   noc_in_buffer #(.DATASIZE(DW), .DEPTH(DEPTH), .AW(AW)) dut (
      .rc_clk   (rc_clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .empty    (empty),
      .full     (full),
      .count    (count),
      .overflow (overflow)
   );

   always #5 rc_clk = ~rc_clk;

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: a queue of stored flits plus the output register.
   logic [DW-1:0] q[$];
   logic          m_ovf = 1'b0;
   logic          m_valid = 1'b0;
   logic [DW-1:0] m_data = '0;

   typedef struct {
      logic          vin;
      logic [DW-1:0] din;
      logic          rdy;
      logic          ev;
      logic [DW-1:0] ed;
      int            ec;
      logic          eo;
   } vec_t;
   vec_t tbl[16];

   function automatic vec_t mk(logic vin, logic [DW-1:0] din, logic rdy,
                               logic ev, logic [DW-1:0] ed, int ec, logic eo);
      vec_t v;
      v.vin = vin; v.din = din; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.ec = ec; v.eo = eo;
      return v;
   endfunction

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic cyc(logic vin, logic [DW-1:0] din, logic rdy);
      bit was_full, was_empty;
      bus.link_valid_in = vin;
      bus.link_data_in  = din;
      bus.fifo_ready    = rdy;
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rdy && !was_empty) begin
         m_data  = q.pop_front();
         m_valid = 1'b1;
      end else begin
         m_valid = 1'b0;
      end
      if (vin && !was_full) q.push_back(din);
      if (vin && was_full) m_ovf = 1'b1;
      @(posedge rc_clk);
      #1;
   endtask

   task automatic check_model(string tag);
      chk({tag, ".count"}, 64'(count), 64'(q.size()));
      chk({tag, ".empty"}, 64'(empty), 64'(q.size() == 0));
      chk({tag, ".full"}, 64'(full), 64'(q.size() == DEPTH));
      chk({tag, ".ready"}, 64'(bus.link_ready_out), 64'(q.size() != DEPTH));
      chk({tag, ".valid"}, 64'(bus.valid_out), 64'(m_valid));
      chk({tag, ".data"}, 64'(bus.data_out), 64'(m_data));
      chk({tag, ".ovf"}, 64'(overflow), 64'(m_ovf));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DW-1:0] d;
      bus.link_valid_in = 1'b0;
      bus.link_data_in  = '0;
      bus.fifo_ready    = 1'b0;

      // Vector table: three-flit ordering, then fill/overflow/drain.
      tbl[0]  = mk(1, 40'h01_0000_0001, 0, 0, 40'h0, 1, 0);
      tbl[1]  = mk(1, 40'h02_0000_0002, 0, 0, 40'h0, 2, 0);
      tbl[2]  = mk(1, 40'h03_0000_0003, 0, 0, 40'h0, 3, 0);
      tbl[3]  = mk(0, 40'h0, 1, 1, 40'h01_0000_0001, 2, 0);
      tbl[4]  = mk(0, 40'h0, 1, 1, 40'h02_0000_0002, 1, 0);
      tbl[5]  = mk(0, 40'h0, 1, 1, 40'h03_0000_0003, 0, 0);
      tbl[6]  = mk(0, 40'h0, 1, 0, 40'h03_0000_0003, 0, 0);
      tbl[7]  = mk(1, 40'h11, 0, 0, 40'h03_0000_0003, 1, 0);
      tbl[8]  = mk(1, 40'h22, 0, 0, 40'h03_0000_0003, 2, 0);
      tbl[9]  = mk(1, 40'h33, 0, 0, 40'h03_0000_0003, 3, 0);
      tbl[10] = mk(1, 40'h44, 0, 0, 40'h03_0000_0003, 4, 0);
      tbl[11] = mk(1, 40'hAA, 0, 0, 40'h03_0000_0003, 4, 1);
      tbl[12] = mk(0, 40'h0, 1, 1, 40'h11, 3, 1);
      tbl[13] = mk(0, 40'h0, 1, 1, 40'h22, 2, 1);
      tbl[14] = mk(0, 40'h0, 1, 1, 40'h33, 1, 1);
      tbl[15] = mk(0, 40'h0, 1, 1, 40'h44, 0, 1);

      // Reset state.
      repeat (2) @(posedge rc_clk);
      #1;
      check_model("reset");
      @(negedge rc_clk);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].vin, tbl[i].din, tbl[i].rdy);
         chk($sformatf("tbl%0d.valid", i), 64'(bus.valid_out), 64'(tbl[i].ev));
         chk($sformatf("tbl%0d.data", i), 64'(bus.data_out), 64'(tbl[i].ed));
         chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].ec));
         chk($sformatf("tbl%0d.ovf", i), 64'(overflow), 64'(tbl[i].eo));
         if (i == 10) begin
            chk("tbl.full", 64'(full), 64'd1);
            chk("tbl.ready", 64'(bus.link_ready_out), 64'd0);
         end
      end
      chk("tbl.empty_end", 64'(empty), 64'd1);

      // Push and fifo_ready together on an empty buffer: no bypass.
      cyc(1, 40'h55, 1);
      chk("nobypass.valid", 64'(bus.valid_out), 64'd0);
      chk("nobypass.count", 64'(count), 64'd1);
      cyc(0, 40'h0, 1);
      chk("nobypass.valid2", 64'(bus.valid_out), 64'd1);
      chk("nobypass.data2", 64'(bus.data_out), 64'h55);

      // Steady streaming at occupancy 2 across several pointer wraps.
      cyc(1, 40'h1000, 0);
      cyc(1, 40'h1001, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 40'h1002 + 40'(i), 1);
         chk("stream.count", 64'(count), 64'd2);
         chk("stream.valid", 64'(bus.valid_out), 64'd1);
         chk("stream.data", 64'(bus.data_out), 64'h1000 + 64'(i));
      end

      // Alternating fifo_ready with pushes obeying link_ready_out.
      for (int i = 0; i < 8; i++) begin
         d = 40'h2000 + 40'(i);
         cyc(bus.link_ready_out, d, (i % 2) == 0);
         check_model("alt");
      end

      // Drain, then set up count=3 with valid_out=1 and reset mid-cycle.
      for (int i = 0; i < 8 && q.size() != 0; i++) cyc(0, 40'h0, 1);
      cyc(1, 40'h3000, 0);
      cyc(1, 40'h3001, 0);
      cyc(1, 40'h3002, 0);
      cyc(1, 40'h3003, 1);
      check_model("prerst");
      #2;
      rst_n = 1'b0;
      #1;
      q.delete();
      m_ovf = 1'b0; m_valid = 1'b0; m_data = '0;
      chk("rst.valid", 64'(bus.valid_out), 64'd0);
      chk("rst.count", 64'(count), 64'd0);
      chk("rst.ovf", 64'(overflow), 64'd0);
      chk("rst.ready", 64'(bus.link_ready_out), 64'd1);
      @(negedge rc_clk);
      rst_n = 1'b1;
      cyc(1, 40'h77, 0);
      cyc(0, 40'h0, 1);
      chk("postrst.valid", 64'(bus.valid_out), 64'd1);
      chk("postrst.data", 64'(bus.data_out), 64'h77);

      // Random traffic, sometimes ignoring link_ready_out to exercise overflow.
      for (int i = 0; i < 400; i++) begin
         d = {8'($urandom), 32'($urandom)};
         cyc(($urandom_range(0, 3) != 0), d, ($urandom_range(0, 2) != 0));
         check_model("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/noc_in_buffer.md
Name: noc_in_buffer

Overview:
- Per-input-port ingress FIFO of the router. It sits directly upstream of the route-compute stage.
- Accepts flits from the neighbouring router's link and holds them until the route-compute stage asserts fifo_ready.
- Presents each popped flit one cycle later on data_out/valid_out. These connect to the route-compute stage's data_in/valid_in.
- Also drives the link's backpressure signal and a sticky overflow flag for debug.

Parameters:
- DATASIZE, 40: flit width (src 4b, dst 4b, timestamp, payload, type 2b; bit 0 = request/type flag). Stored opaquely, never decoded.
- DEPTH, 4: FIFO entries. Must be a power of two, ≥2.
- AW, $clog2(DEPTH): pointer index width. Pointers are AW+1 bits wide, including the wrap bit.

Ports:
- rc_clk  input  1  router clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset, released synchronously by the top level.
- link_data_in  input  DATASIZE  flit from the upstream link.
- link_valid_in  input  1  link_data_in valid this cycle.
- link_ready_out  input-side output  1  buffer can accept a flit this cycle (= !full, combinational from registers).
- fifo_ready  input  1  pop request from the route-compute stage.
- data_out  output  DATASIZE  popped flit, registered.
- valid_out  output  1  data_out holds a freshly popped flit this cycle (one-cycle pulse per pop).
- empty  output  1  occupancy == 0.
- full  output  1  occupancy == DEPTH.
- count  output  AW+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: a flit was offered while full.

Behaviour:
- Reset (async, rst_n=0): wr_ptr=0, rd_ptr=0, data_out=0, valid_out=0, overflow=0. Hence empty=1, full=0, count=0, link_ready_out=1.
- Memory contents are not reset.
- Pointers:
  - Index = ptr[AW-1:0].
  - empty when wr_ptr == rd_ptr.
  - full when indices are equal and wrap bits differ.
  - count = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - Pointers wrap naturally; no explicit wrap logic is needed.
- Write (push = link_valid_in && !full):
  - mem[wr_idx] <= link_data_in and wr_ptr++ at the posedge.
  - If link_valid_in && full: the flit is dropped, nothing is written, overflow <= 1 and stays set until reset.
- Read (pop = fifo_ready && !empty):
  - At the posedge, data_out <= mem[rd_idx], rd_ptr++, valid_out <= 1.
  - If no pop: valid_out <= 0 and data_out holds its last value.
  - Latency is exactly 1 cycle from the sampled fifo_ready to valid_out.
  - fifo_ready while empty is a no-op: valid_out=0, pointers unchanged.
- Simultaneous push and pop:
  - Both occur in the same cycle; count is unchanged.
  - When full, a pop does not enable a same-cycle push, because push is gated on the registered full. The offered flit is dropped and sets overflow. Upstream is required to obey link_ready_out.
  - When empty, a push and fifo_ready in the same cycle: only the push happens, with no write-to-read bypass. The flit can be popped in the following cycle at the earliest.
  - Minimum latency from link to valid_out is 2 cycles.
- Ordering: strict FIFO; flits leave in arrival order, bit-exact.
- Throughput: one push and one pop per cycle sustained.
- fifo_ready may deassert at any cycle, including while the route-compute stage is stalled by its downstream buffer being full. The buffer simply holds; no flit is lost or duplicated.
- Reset mid-operation: all in-flight entries are discarded and valid_out drops immediately (async). After release the buffer behaves as freshly empty, and the first pop returns the first flit written after reset.
- No combinational path from fifo_ready to data_out/valid_out. link_ready_out depends only on registers.

Test Plan:
- Reset, then push 0x01_0000_0001, 0x02_0000_0002, 0x03_0000_0003 with fifo_ready=0 -> count=3, valid_out=0. Then fifo_ready=1 for 3 cycles -> valid_out=1 for 3 consecutive cycles, data_out = 0x..01, 0x..02, 0x..03 in order. empty=1 afterwards.
- Push DEPTH=4 flits with no pops -> full=1, link_ready_out=0, count=4. Offer a 5th flit 0xAA -> not stored, overflow=1 and remains 1. Draining 4 pops returns the original 4 flits only.
- Empty buffer, same cycle push 0x55 and fifo_ready=1 -> no valid_out next cycle. fifo_ready held -> valid_out=1 with data_out=0x55 on the second cycle after the push.
- Steady streaming: push and pop every cycle for 20 cycles starting at count=2 -> count stays 2, pointers wrap at least twice, output sequence matches input exactly with 2-entry lag.
- Alternate fifo_ready 1/0 for 8 cycles with continuous link pushes obeying link_ready_out -> every pop produces a single-cycle valid_out. data_out is held while fifo_ready=0. No loss or duplication against a scoreboard.
- Assert rst_n=0 mid-cycle with count=3 and valid_out=1 -> valid_out=0, count=0, overflow=0 immediately. After release, push 0x77 and pop -> data_out=0x77.
